// File: rtl/prbs_pkg.sv
// Shared definitions for the LFSR test path: checker state encoding, default
// polynomial and the next-bit predictor that generator and checker both use.
package prbs_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_TAP_A = 1;
    localparam int DEF_TAP_B = 7;
    localparam int MAX_N     = 32;

    typedef enum logic [1:0] {
        FILL,
        VERIFY,
        LOCKED
    } prbs_state_e;

    // Register value is zero-extended to MAX_N so one definition serves any width.
    function automatic logic predictBit(input logic [MAX_N-1:0] r,
                                        input logic [4:0]       tapA,
                                        input logic [4:0]       tapB);
        return r[tapA] ^ r[tapB];
    endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// CW-bit saturating event counter; a clear in the same cycle as an increment
// is applied first, so the result is 1.
module prbs_sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q;
        if (inc_i && (cnt_d != '1)) begin
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the Fibonacci LFSR test stream. It locks after a
// run of correct predictions, then counts errors against a free-running reference.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int TAP_A    = DEF_TAP_A,
    parameter int TAP_B    = DEF_TAP_B,
    parameter int LOCK_CNT = 16,
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_valid,
    input  logic          clr_cnt,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_cnt
);

    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN + 1);
    localparam int EW = $clog2(LOSS_THR + 1);

    prbs_state_e   state_q, state_d;
    logic [N-1:0]  r_q, r_d;
    logic [FW-1:0] fillCnt_q, fillCnt_d;
    logic [MW-1:0] matchCnt_q, matchCnt_d;
    logic [WW-1:0] winCnt_q, winCnt_d;
    logic [EW-1:0] winErr_q, winErr_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic          pred;
    logic          hit;

    assign pred = predictBit(MAX_N'(r_q), 5'(TAP_A), 5'(TAP_B));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            r_q        <= '0;
            fillCnt_q  <= '0;
            matchCnt_q <= '0;
            winCnt_q   <= '0;
            winErr_q   <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            fillCnt_q  <= fillCnt_d;
            matchCnt_q <= matchCnt_d;
            winCnt_q   <= winCnt_d;
            winErr_q   <= winErr_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    // In VERIFY the received bit is loaded so the register re-seeds itself;
    // in LOCKED the prediction is loaded so a flipped bit costs exactly one error.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        fillCnt_d  = fillCnt_q;
        matchCnt_d = matchCnt_q;
        winCnt_d   = winCnt_q;
        winErr_d   = winErr_q;
        hit        = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                FILL: begin
                    r_d = {r_q[N-2:0], din};
                    if (fillCnt_q == FW'(N - 1)) begin
                        state_d    = VERIFY;
                        fillCnt_d  = '0;
                        matchCnt_d = '0;
                    end else begin
                        fillCnt_d = fillCnt_q + 1'b1;
                    end
                end
                VERIFY: begin
                    r_d = {r_q[N-2:0], din};
                    if ((din == pred) && (r_q != '0)) begin
                        if (matchCnt_q == MW'(LOCK_CNT - 1)) begin
                            state_d    = LOCKED;
                            matchCnt_d = '0;
                            winCnt_d   = '0;
                            winErr_d   = '0;
                        end else begin
                            matchCnt_d = matchCnt_q + 1'b1;
                        end
                    end else begin
                        matchCnt_d = '0;
                    end
                end
                LOCKED: begin
                    r_d = {r_q[N-2:0], pred};
                    hit = (din != pred);
                    if (hit && (winErr_q == EW'(LOSS_THR - 1))) begin
                        state_d   = FILL;
                        fillCnt_d = '0;
                        winCnt_d  = '0;
                        winErr_d  = '0;
                    end else if (winCnt_q == WW'(WIN - 1)) begin
                        winCnt_d = '0;
                        winErr_d = '0;
                    end else begin
                        winCnt_d = winCnt_q + 1'b1;
                        winErr_d = winErr_q + EW'(hit);
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_comb begin
        locked_d = (state_d == LOCKED);
        err_d    = hit;
    end

    prbs_sat_counter #(
        .CW(CW)
    ) u_errCnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(clr_cnt),
        .inc_i(err_d),
        .cnt_o(err_cnt)
    );

    assign locked = locked_q;
    assign err    = err_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: stimulus queues the expected outputs for each
// driven cycle and a negedge monitor pops and compares them.
module tb_prbs_checker;

    typedef struct {
        string      name;
        logic       expLocked;
        logic       expErr;
        logic [3:0] expCnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       clr_cnt;
    logic       locked;
    logic       err;
    logic [3:0] err_cnt;

    exp_t       sb[$];
    exp_t       cur;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] genQ;

    always #5 clk = ~clk;

    prbs_checker #(
        .N       (8),
        .TAP_A   (1),
        .TAP_B   (7),
        .LOCK_CNT(16),
        .WIN     (64),
        .LOSS_THR(8),
        .CW      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    // Reference generator: Fibonacci LFSR, feedback q[1]^q[7] shifted in at bit 0.
    task automatic genBit(output logic b);
        b    = genQ[1] ^ genQ[7];
        genQ = {genQ[6:0], b};
    endtask

    task automatic applyStimulus(input logic r, input logic d, input logic v, input logic c,
                                 input logic eL, input logic eE, input logic [3:0] eC,
                                 input string nm);
        exp_t e;
        rst       = r;
        din       = d;
        din_valid = v;
        clr_cnt   = c;
        @(posedge clk);
        e.name      = nm;
        e.expLocked = eL;
        e.expErr    = eE;
        e.expCnt    = eC;
        sb.push_back(e);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (locked !== e.expLocked) begin
            errors++;
            $display("[TB] FAIL %s locked got %0b want %0b", e.name, locked, e.expLocked);
        end
        checks++;
        if (err !== e.expErr) begin
            errors++;
            $display("[TB] FAIL %s err got %0b want %0b", e.name, err, e.expErr);
        end
        checks++;
        if (err_cnt !== e.expCnt) begin
            errors++;
            $display("[TB] FAIL %s err_cnt got %0d want %0d", e.name, err_cnt, e.expCnt);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "reset_hold");
    endtask

    // 8 fill bits plus 16 matches: locked rises with the 24th valid bit.
    task automatic lockFromSeed(input logic [7:0] seed, input string nm);
        logic b;
        genQ = seed;
        for (int k = 1; k <= 24; k++) begin
            genBit(b);
            applyStimulus(1'b0, b, 1'b1, 1'b0, (k >= 24), 1'b0, 4'd0, nm);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                checkOutput(cur);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: stimulus did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic b;
        logic gapV;
        logic junk;
        int   nErr;
        int   v;
        int   cyc;

        rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;

        // Reset state, then lock-up from seed A5 and stay locked cleanly.
        doReset();
        genQ = 8'hA5;
        for (int k = 1; k <= 40; k++) begin
            genBit(b);
            applyStimulus(1'b0, b, 1'b1, 1'b0, (k >= 24), 1'b0, 4'd0, "lockup");
        end

        // Single error, gaps with garbage data, clear-with-error, plain clear.
        for (int k = 0; k < 3; k++) begin
            genBit(b);
            applyStimulus(1'b0, b, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "pre_err");
        end
        genBit(b);
        applyStimulus(1'b0, ~b, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, "single_err");
        for (int k = 0; k < 15; k++) begin
            genBit(b);
            applyStimulus(1'b0, b, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, "post_err");
        end
        for (int k = 0; k < 4; k++) begin
            junk = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, junk, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "locked_gap");
        end
        genBit(b);
        applyStimulus(1'b0, ~b, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, "second_err");
        for (int k = 0; k < 5; k++) begin
            genBit(b);
            applyStimulus(1'b0, b, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, "clean2");
        end
        genBit(b);
        applyStimulus(1'b0, ~b, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, "clr_and_err");
        genBit(b);
        applyStimulus(1'b0, b, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "clr_only");
        for (int k = 0; k < 5; k++) begin
            genBit(b);
            applyStimulus(1'b0, b, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "after_clr");
        end

        // Loss of lock: errors on every other bit, 8th one drops lock, then relock.
        doReset();
        lockFromSeed(8'hA5, "relock_a");
        for (int p = 1; p <= 16; p++) begin
            genBit(b);
            if (p % 2 == 0) begin
                applyStimulus(1'b0, ~b, 1'b1, 1'b0, (p < 16), 1'b1, 4'(p / 2), "loss_err");
            end else begin
                applyStimulus(1'b0, b, 1'b1, 1'b0, 1'b1, 1'b0, 4'(p / 2), "loss_clean");
            end
        end
        for (int m = 1; m <= 28; m++) begin
            genBit(b);
            applyStimulus(1'b0, b, 1'b1, 1'b0, (m >= 24), 1'b0, 4'd8, "relock_after_loss");
        end

        // All-zero input never locks and never counts.
        doReset();
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "all_zero");
        end

        // Randomly gapped valid on a clean stream: lock after exactly 24 valid bits.
        doReset();
        genQ = 8'hA5;
        v    = 0;
        cyc  = 0;
        while ((v < 40) && (cyc < 600)) begin
            gapV = 1'($urandom_range(0, 1));
            if (gapV) begin
                genBit(b);
                v++;
                applyStimulus(1'b0, b, 1'b1, 1'b0, (v >= 24), 1'b0, 4'd0, "gapped_bit");
            end else begin
                junk = 1'($urandom_range(0, 1));
                applyStimulus(1'b0, junk, 1'b0, 1'b0, (v >= 24), 1'b0, 4'd0, "gapped_hold");
            end
            cyc++;
        end
        checks++;
        if (v < 40) begin
            errors++;
            $display("[TB] FAIL gapped_budget valid bits got %0d want 40", v);
        end

        // Saturation: one error every 10 bits keeps each window below the loss threshold.
        doReset();
        lockFromSeed(8'h3C, "relock_b");
        nErr = 0;
        for (int p = 1; p <= 170; p++) begin
            genBit(b);
            if (p % 10 == 0) begin
                nErr++;
                applyStimulus(1'b0, ~b, 1'b1, 1'b0, 1'b1, 1'b1,
                              (nErr > 15) ? 4'd15 : 4'(nErr), "sat_err");
            end else begin
                applyStimulus(1'b0, b, 1'b1, 1'b0, 1'b1, 1'b0,
                              (nErr > 15) ? 4'd15 : 4'(nErr), "sat_clean");
            end
        end

        // Reset while locked with a bad bit present: everything clears at the edge.
        genBit(b);
        applyStimulus(1'b1, ~b, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "rst_locked");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "rst_release");

        for (int i = 0; (i < 4) && (sb.size() != 0); i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending entries got %0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
